// File: rtl/multiport_regfile_pkg.sv
// Shared widths and helpers for the multi-port register file.
// Covers port-vector slicing and the write-port winner selection.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int PC_W      = 32;
    localparam int MAX_WR    = 2;
    localparam int WR_IDX_W  = 1;

    typedef struct packed {
        logic                vld;
        logic [WR_IDX_W-1:0] idx;
    } wsel_t;

    // Low bit of port k inside a packed vector of w-bit lanes.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

    // The highest-index hit wins when several write ports target one register.
    function automatic wsel_t wr_select(input logic [MAX_WR-1:0] hit);
        wsel_t s;
        s.vld = 1'b0;
        s.idx = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (hit[j]) begin
                s.vld = 1'b1;
                s.idx = WR_IDX_W'(j);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Decode/writeback-facing bundle of the register file.
// The master side drives reads, writes and issues; the slave side returns data and pending bits.
interface multiport_regfile_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR*PC_W-1:0]   wr_pc;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr, flush,
        input  rd_data, rd_pending
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr, flush,
        output rd_data, rd_pending
    );
endinterface

// File: rtl/multiport_regfile_bypass_mux.sv
// One read port: stored value, overridden by the winning same-cycle write.
// Purely combinational, zero latency; no backpressure.
module rf_bypass_mux
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        stored,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_data
);
    logic [NUM_WR-1:0] hit;
    logic [MAX_WR-1:0] hit_ext;
    wsel_t             sel;

    always_comb begin
        hit     = '0;
        hit_ext = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            hit[j] = wr_en[j] && (wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == rd_addr);
        end
        hit_ext[NUM_WR-1:0] = hit;
        sel = wr_select(hit_ext);

        rd_data = stored;
        if (sel.vld) begin
            rd_data = wr_data[slice_lo(int'(sel.idx), DATA_W) +: DATA_W];
        end
        // Register 0 is hardwired; it must not even pass bypassed data.
        if (ZERO_REG != 0 && rd_addr == '0) begin
            rd_data = '0;
        end
    end
endmodule

// File: rtl/multiport_regfile.sv
// Multi-port GRF with write bypass and a pending-write scoreboard (trace option: RF_TRACE_EN).
// Writes land in 1 edge, reads/bypass/pending are same-cycle combinational; no backpressure.
module multiport_regfile
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input logic                Clk,
    input logic                Reset,
    multiport_regfile_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pend_nxt;

    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] wlive;

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j]    = bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W];
        assign wd[j]    = bus.wr_data[slice_lo(j, DATA_W) +: DATA_W];
        assign wlive[j] = bus.wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0);
    end

    // Ascending port order makes the highest-index write to an address the last NBA.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            pending <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wlive[j]) begin
                    regs[wa[j]] <= wd[j];
                end
            end
            pending <= pend_nxt;
        end
    end

    // Order matters: flush, then write clears, then the issue set overrides both.
    always_comb begin
        pend_nxt = bus.flush ? '0 : pending;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wlive[j]) begin
                pend_nxt[wa[j]] = 1'b0;
            end
        end
        if (bus.iss_en) begin
            pend_nxt[bus.iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_nxt[0] = 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = bus.rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];

        rf_bypass_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .rd_addr (ra),
            .stored  (regs[ra]),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_data (bus.rd_data[slice_lo(k, DATA_W) +: DATA_W])
        );

        assign bus.rd_pending[k] = pend_nxt[ra];
    end

`ifdef RF_TRACE_EN
    logic [NUM_WR-1:0] trace_win;

    // A live write is traced only if no higher-index port overwrites the same register.
    always_comb begin
        trace_win = wlive;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int h = j + 1; h < NUM_WR; h++) begin
                if (wlive[h] && wa[h] == wa[j]) begin
                    trace_win[j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (trace_win[j]) begin
                    $display("%d@%h: $%d <= %h", $time,
                             bus.wr_pc[slice_lo(j, PC_W) +: PC_W], wa[j], wd[j]);
                end
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.wr_pc;
`endif
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile with 4 read ports, 2 write ports and a hardwired r0.
module tb_multiport_regfile;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;

    logic Clk;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    multiport_regfile_if #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .NUM_WR (NUM_WR)
    ) bus ();

    multiport_regfile #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .NUM_WR (NUM_WR), .ZERO_REG (1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdd(input int k);
        return bus.rd_data[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [31:0] pnd(input int k);
        return {31'b0, bus.rd_pending[k]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_pc    = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
        bus.wr_en[j]                = 1'b1;
        bus.wr_addr[j*ADDR_W +: ADDR_W] = a;
        bus.wr_data[j*DATA_W +: DATA_W] = d;
        bus.wr_pc[j*32 +: 32]       = 32'h0000_1000 + 32'(j * 4);
    endtask

    task automatic iss(input logic [4:0] a);
        bus.iss_en   = 1'b1;
        bus.iss_addr = a;
    endtask

    task automatic rda(input int k, input logic [4:0] a);
        bus.rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        idle();
        bus.rd_addr = '0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;

        // Arbitrary state, then a reset cycle that also carries a write and an issue.
        wr(0, 5'd1, 32'hAAAA_0001);
        wr(1, 5'd2, 32'hBBBB_0002);
        iss(5'd3);
        tick();
        idle();
        rda(0, 5'd1); rda(1, 5'd2); rda(2, 5'd4); rda(3, 5'd3);
        #1;
        chk("pre_rst_r1", rdd(0), 32'hAAAA_0001);
        chk("pre_rst_pend_r3", pnd(3), 32'd1);
        Reset = 1'b1;
        wr(0, 5'd4, 32'h0000_0044);
        iss(5'd6);
        tick();
        Reset = 1'b0;
        idle();
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            chk($sformatf("rst_data%0d", k), rdd(k), 32'h0);
            chk($sformatf("rst_pend%0d", k), pnd(k), 32'h0);
        end
        rda(0, 5'd6);
        #1;
        chk("rst_pend_r6", pnd(0), 32'h0);

        // Two ports, same register: port 1 wins, bypassed and stored.
        wr(0, 5'd5, 32'h1111_1111);
        wr(1, 5'd5, 32'h2222_2222);
        rda(0, 5'd5);
        #1;
        chk("prio_bypass", rdd(0), 32'h2222_2222);
        tick();
        idle();
        #1;
        chk("prio_stored", rdd(0), 32'h2222_2222);

        // Port 0 alone bypasses too.
        wr(0, 5'd5, 32'h5555_5555);
        #1;
        chk("p0_bypass", rdd(0), 32'h5555_5555);
        tick();
        idle();

        // Register 0 ignores writes and issues.
        wr(1, 5'd0, 32'hDEAD_BEEF);
        iss(5'd0);
        rda(0, 5'd0);
        #1;
        chk("r0_data_now", rdd(0), 32'h0);
        chk("r0_pend_now", pnd(0), 32'h0);
        tick();
        idle();
        #1;
        chk("r0_data_after", rdd(0), 32'h0);
        chk("r0_pend_after", pnd(0), 32'h0);

        // Scoreboard: issue r7, resolve it three cycles later, then issue+write together.
        rda(1, 5'd7);
        iss(5'd7);
        #1;
        chk("r7_pend_t", pnd(1), 32'd1);
        tick();
        idle();
        #1;
        chk("r7_pend_t1", pnd(1), 32'd1);
        tick();
        #1;
        chk("r7_pend_t2", pnd(1), 32'd1);
        tick();
        wr(0, 5'd7, 32'h0000_0005);
        #1;
        chk("r7_data_t3", rdd(1), 32'h0000_0005);
        chk("r7_pend_t3", pnd(1), 32'h0);
        tick();
        idle();
        #1;
        chk("r7_data_t4", rdd(1), 32'h0000_0005);
        chk("r7_pend_t4", pnd(1), 32'h0);
        wr(1, 5'd7, 32'h0000_0006);
        iss(5'd7);
        #1;
        chk("r7_iss_wr_pend", pnd(1), 32'd1);
        chk("r7_iss_wr_data", rdd(1), 32'h0000_0006);
        tick();
        idle();
        #1;
        chk("r7_iss_wr_pend_reg", pnd(1), 32'd1);

        // Flush clears everything except the same-cycle issue.
        iss(5'd3); tick();
        iss(5'd4); tick();
        iss(5'd9); tick();
        idle();
        rda(0, 5'd3); rda(1, 5'd4); rda(2, 5'd9); rda(3, 5'd7);
        #1;
        chk("pre_flush_r3", pnd(0), 32'd1);
        chk("pre_flush_r4", pnd(1), 32'd1);
        chk("pre_flush_r9", pnd(2), 32'd1);
        chk("pre_flush_r7", pnd(3), 32'd1);
        bus.flush = 1'b1;
        iss(5'd9);
        #1;
        chk("flush_now_r3", pnd(0), 32'h0);
        chk("flush_now_r9", pnd(2), 32'd1);
        tick();
        idle();
        #1;
        chk("flush_r3", pnd(0), 32'h0);
        chk("flush_r4", pnd(1), 32'h0);
        chk("flush_r9", pnd(2), 32'd1);
        chk("flush_r7", pnd(3), 32'h0);

        // Four independent reads, one of them bypassed.
        wr(0, 5'd10, 32'hA0A0_A0A0);
        wr(1, 5'd11, 32'hB1B1_B1B1);
        tick();
        idle();
        wr(0, 5'd12, 32'hC2C2_C2C2);
        wr(1, 5'd11, 32'hDDDD_DDDD);
        rda(0, 5'd5); rda(1, 5'd7); rda(2, 5'd10); rda(3, 5'd12);
        #1;
        chk("quad_r5", rdd(0), 32'h5555_5555);
        chk("quad_r7", rdd(1), 32'h0000_0006);
        chk("quad_r10", rdd(2), 32'hA0A0_A0A0);
        chk("quad_r12_byp", rdd(3), 32'hC2C2_C2C2);
        tick();
        idle();
        rda(0, 5'd11);
        #1;
        chk("r11_overwrite", rdd(0), 32'hDDDD_DDDD);
        chk("r12_stored", rdd(3), 32'hC2C2_C2C2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
